// File: rtl/status_reg_stack.sv
// Status register with masked ALU / full decoder writes and a LIFO save stack
// for interrupt entry/return, with a sticky overflow/underflow/conflict flag.
module status_reg_stack #(
   parameter int NumStatusBits = 3,
   parameter int StackDepth    = 4
) (
   input  logic                             clk,
   input  logic                             res_n,
   input  logic                             wr_en,
   input  logic                             sel_stat_in_alu_decoder,
   input  logic [NumStatusBits-1:0]         alu_status,
   input  logic [NumStatusBits-1:0]         alu_mask,
   input  logic [NumStatusBits-1:0]         dec_status,
   input  logic                             push,
   input  logic                             pop,
   input  logic                             err_clr,
   output logic [NumStatusBits-1:0]         status,
   output logic [$clog2(StackDepth+1)-1:0]  stack_level,
   output logic                             stack_full,
   output logic                             stack_empty,
   output logic                             stack_err
);

   localparam int LW = $clog2(StackDepth+1);

   logic [NumStatusBits-1:0] status_r;
   logic [LW-1:0]            level_r;
   logic                     err_r;
   logic [NumStatusBits-1:0] slots_r [StackDepth];

   logic                     full_s;
   logic                     empty_s;
   logic                     push_ok_s;
   logic                     pop_ok_s;
   logic                     err_evt_s;
   logic [NumStatusBits-1:0] top_s;
   logic [NumStatusBits-1:0] status_nxt_s;
   logic [LW-1:0]            level_nxt_s;

   assign full_s  = (level_r == LW'(StackDepth));
   assign empty_s = (level_r == LW'(0));

   // Classify stack requests: conflicting or impossible requests only raise the error.
   always_comb begin
      push_ok_s = push & ~pop & ~full_s;
      pop_ok_s  = pop & ~push & ~empty_s;
      err_evt_s = (push & pop) | (push & ~pop & full_s) | (pop & ~push & empty_s);
   end

   // Top-of-stack read; compare-based select keeps the level width independent of the slot index width.
   always_comb begin
      top_s = '0;
      for (int i = 0; i < StackDepth; i++) begin
         if (level_r == LW'(i + 1)) begin
            top_s = slots_r[i];
         end else begin
            top_s = top_s;
         end
      end
   end

   // Next status and level: a successful pop overrides any write in the same cycle.
   always_comb begin
      status_nxt_s = status_r;
      level_nxt_s  = level_r;
      if (pop_ok_s) begin
         status_nxt_s = top_s;
         level_nxt_s  = level_r - LW'(1);
      end else if (wr_en) begin
         if (sel_stat_in_alu_decoder) begin
            status_nxt_s = (status_r & ~alu_mask) | (alu_status & alu_mask);
         end else begin
            status_nxt_s = dec_status;
         end
      end else begin
         status_nxt_s = status_r;
      end
      if (push_ok_s) begin
         level_nxt_s = level_r + LW'(1);
      end else begin
         level_nxt_s = level_nxt_s;
      end
   end

   // State registers; a push saves the pre-edge status into the slot at the current level.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         status_r <= '0;
         level_r  <= '0;
         err_r    <= 1'b0;
         for (int i = 0; i < StackDepth; i++) begin
            slots_r[i] <= '0;
         end
      end else begin
         status_r <= status_nxt_s;
         level_r  <= level_nxt_s;
         if (err_evt_s) begin
            err_r <= 1'b1;
         end else if (err_clr) begin
            err_r <= 1'b0;
         end else begin
            err_r <= err_r;
         end
         for (int i = 0; i < StackDepth; i++) begin
            if (push_ok_s && (level_r == LW'(i))) begin
               slots_r[i] <= status_r;
            end else begin
               slots_r[i] <= slots_r[i];
            end
         end
      end
   end

   assign status      = status_r;
   assign stack_level = level_r;
   assign stack_full  = full_s;
   assign stack_empty = empty_s;
   assign stack_err   = err_r;

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed, table-driven bench for status_reg_stack with default parameters
// (3 status bits, 4 slots), plus hand-written reset sequences.
module tb_status_reg_stack;

   typedef struct {
      logic       wr_en;
      logic       sel;
      logic [2:0] alu;
      logic [2:0] mask;
      logic [2:0] dec;
      logic       push;
      logic       pop;
      logic       clr;
      logic [2:0] e_status;
      logic [2:0] e_level;
      logic       e_full;
      logic       e_empty;
      logic       e_err;
   } vec_t;

   logic       clk;
   logic       res_n;
   logic       wr_en;
   logic       sel_stat_in_alu_decoder;
   logic [2:0] alu_status;
   logic [2:0] alu_mask;
   logic [2:0] dec_status;
   logic       push;
   logic       pop;
   logic       err_clr;
   logic [2:0] status;
   logic [2:0] stack_level;
   logic       stack_full;
   logic       stack_empty;
   logic       stack_err;

   vec_t vt [40];
   int   nv;
   int   total;
   int   passed;

   status_reg_stack dut (
      .clk(clk),
      .res_n(res_n),
      .wr_en(wr_en),
      .sel_stat_in_alu_decoder(sel_stat_in_alu_decoder),
      .alu_status(alu_status),
      .alu_mask(alu_mask),
      .dec_status(dec_status),
      .push(push),
      .pop(pop),
      .err_clr(err_clr),
      .status(status),
      .stack_level(stack_level),
      .stack_full(stack_full),
      .stack_empty(stack_empty),
      .stack_err(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] s, input logic [2:0] l,
                          input logic f, input logic e, input logic er);
      chk({tag, ".status"}, {5'd0, status}, {5'd0, s});
      chk({tag, ".level"},  {5'd0, stack_level}, {5'd0, l});
      chk({tag, ".full"},   {7'd0, stack_full}, {7'd0, f});
      chk({tag, ".empty"},  {7'd0, stack_empty}, {7'd0, e});
      chk({tag, ".err"},    {7'd0, stack_err}, {7'd0, er});
   endtask

   task automatic add(input logic w, input logic sl, input logic [2:0] a, input logic [2:0] m,
                      input logic [2:0] d, input logic pu, input logic po, input logic c,
                      input logic [2:0] es, input logic [2:0] el, input logic ef,
                      input logic ee, input logic er);
      vt[nv] = '{w, sl, a, m, d, pu, po, c, es, el, ef, ee, er};
      nv++;
   endtask

   task automatic idle();
      wr_en = 1'b0; sel_stat_in_alu_decoder = 1'b0;
      alu_status = 3'b000; alu_mask = 3'b000; dec_status = 3'b000;
      push = 1'b0; pop = 1'b0; err_clr = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      wr_en = v.wr_en; sel_stat_in_alu_decoder = v.sel;
      alu_status = v.alu; alu_mask = v.mask; dec_status = v.dec;
      push = v.push; pop = v.pop; err_clr = v.clr;
   endtask

   initial begin
      total = 0; passed = 0; nv = 0;
      idle();
      res_n = 1'b0;
      push = 1'b1;
      #2;
      chk_all("reset0", 3'b000, 3'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk_all("reset_push", 3'b000, 3'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      idle();
      res_n = 1'b1;

      //   wr sel alu     mask    dec     pu po cl  status  lvl full empty err
      add(1, 1, 3'b101, 3'b001, 3'b000, 0, 0, 0, 3'b001, 3'd0, 0, 1, 0);
      add(1, 1, 3'b101, 3'b110, 3'b000, 0, 0, 0, 3'b101, 3'd0, 0, 1, 0);
      add(1, 0, 3'b000, 3'b000, 3'b011, 0, 0, 0, 3'b011, 3'd0, 0, 1, 0);
      add(0, 1, 3'b111, 3'b111, 3'b100, 0, 0, 0, 3'b011, 3'd0, 0, 1, 0);
      add(1, 0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 3'b000, 3'd1, 0, 0, 0);
      add(1, 0, 3'b000, 3'b000, 3'b111, 0, 1, 0, 3'b011, 3'd0, 0, 1, 0);
      add(1, 0, 3'b000, 3'b000, 3'b001, 0, 0, 0, 3'b001, 3'd0, 0, 1, 0);
      add(1, 0, 3'b000, 3'b000, 3'b010, 1, 0, 0, 3'b010, 3'd1, 0, 0, 0);
      add(1, 0, 3'b000, 3'b000, 3'b011, 1, 0, 0, 3'b011, 3'd2, 0, 0, 0);
      add(1, 0, 3'b000, 3'b000, 3'b100, 1, 0, 0, 3'b100, 3'd3, 0, 0, 0);
      add(1, 0, 3'b000, 3'b000, 3'b111, 1, 0, 0, 3'b111, 3'd4, 1, 0, 0);
      add(1, 0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 3'b000, 3'd4, 1, 0, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 0, 1, 0, 3'b100, 3'd3, 0, 0, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 0, 1, 0, 3'b011, 3'd2, 0, 0, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 0, 1, 0, 3'b010, 3'd1, 0, 0, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 0, 1, 0, 3'b001, 3'd0, 0, 1, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 3'b001, 3'd0, 0, 1, 0);
      add(1, 1, 3'b111, 3'b111, 3'b000, 0, 1, 0, 3'b111, 3'd0, 0, 1, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 3'b111, 3'd0, 0, 1, 0);
      add(0, 0, 3'b000, 3'b000, 3'b000, 1, 1, 0, 3'b111, 3'd0, 0, 1, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 3'b111, 3'd1, 0, 0, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 1, 1, 1, 3'b111, 3'd1, 0, 0, 1);
      add(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 3'b111, 3'd1, 0, 0, 0);
      add(0, 0, 3'b000, 3'b000, 3'b000, 0, 1, 0, 3'b111, 3'd0, 0, 1, 0);
      add(1, 1, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b111, 3'd0, 0, 1, 0);
      add(1, 0, 3'b000, 3'b000, 3'b110, 1, 0, 0, 3'b110, 3'd1, 0, 0, 0);
      add(0, 0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 3'b110, 3'd2, 0, 0, 0);
      add(0, 0, 3'b000, 3'b000, 3'b000, 1, 1, 0, 3'b110, 3'd2, 0, 0, 1);

      for (int i = 0; i < nv; i++) begin
         @(negedge clk);
         drive(vt[i]);
         @(posedge clk); #1;
         chk_all($sformatf("vec%0d", i), vt[i].e_status, vt[i].e_level,
                 vt[i].e_full, vt[i].e_empty, vt[i].e_err);
      end

      // Asynchronous reset mid-cycle with level 2, status 110, error set.
      @(negedge clk);
      idle();
      @(posedge clk); #3;
      res_n = 1'b0;
      push = 1'b1;
      #1;
      chk_all("async_rst", 3'b000, 3'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk_all("rst_hold", 3'b000, 3'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      idle();
      res_n = 1'b1;
      #1;
      chk_all("rst_release", 3'b000, 3'd0, 1'b0, 1'b1, 1'b0);

      // Pop right after reset is an underflow; status stays 0.
      @(negedge clk);
      pop = 1'b1;
      @(posedge clk); #1;
      chk_all("post_rst_pop", 3'b000, 3'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
